// File: rtl/btn_debounce_apb.sv
// Four-button debouncer with an APB register interface: synchronizers, per-button
// debounce FSMs, sticky press/release events and a level interrupt.
module btn_debounce_apb #(
  parameter int          NBTN    = 4,
  parameter logic [15:0] DEB_RST = 16'd1000
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [9:0]  paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  input  logic [3:0]  buttons,
  output logic        irq
);

  // state  | meaning
  // STABLE | synchronized input equals debounced level, counter idle at 0
  // COUNT  | synchronized input differs from level, counting consecutive edges
  typedef enum logic {STABLE, COUNT} deb_state_t;

  localparam logic [9:0] ADDR_LEVEL = 10'h000;
  localparam logic [9:0] ADDR_EVENT = 10'h002;
  localparam logic [9:0] ADDR_CTRL  = 10'h004;
  localparam logic [9:0] ADDR_LIMIT = 10'h006;

  logic [NBTN-1:0] sync1_q, sync2_q;
  logic [NBTN-1:0] level_q, level_d;
  deb_state_t      state_q [NBTN];
  deb_state_t      state_d [NBTN];
  logic [15:0]     cnt_q   [NBTN];
  logic [15:0]     cnt_d   [NBTN];
  logic [7:0]      event_q, event_d;
  logic [8:0]      ctrl_q;
  logic [15:0]     limit_q;
  logic [15:0]     limit_m1;
  logic            wr_en, rd_en;
  logic [NBTN-1:0] press_set, rel_set;
  logic [7:0]      event_clr;

  assign wr_en  = psel & penable & pwrite;
  assign rd_en  = psel & penable & ~pwrite;
  assign pready = 1'b1;

  // counter+1 >= L rewritten as counter >= L-1; a limit of 0 behaves as 1
  assign limit_m1 = (limit_q == 16'd0) ? 16'd0 : limit_q - 16'd1;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= 16'd0;
      end
      level_q <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
    end
  end

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!ctrl_q[8]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = 16'd0;
      end else begin
        case (state_q[i])
          STABLE, COUNT: begin
            if (sync2_q[i] == level_q[i]) begin
              state_d[i] = STABLE;
              cnt_d[i]   = 16'd0;
            end else if (cnt_q[i] >= limit_m1) begin
              level_d[i] = sync2_q[i];
              state_d[i] = STABLE;
              cnt_d[i]   = 16'd0;
            end else begin
              state_d[i] = COUNT;
              cnt_d[i]   = (cnt_q[i] == 16'hFFFF) ? cnt_q[i] : cnt_q[i] + 16'd1;
            end
          end
          default: begin
            state_d[i] = STABLE;
            cnt_d[i]   = 16'd0;
          end
        endcase
      end
    end
  end

  assign press_set = level_d & ~level_q;
  assign rel_set   = ~level_d & level_q;
  assign event_clr = (wr_en && paddr == ADDR_EVENT) ? pwdata[7:0] : 8'h00;
  // a set landing on the same edge as its clear wins
  assign event_d   = (event_q & ~event_clr) | {rel_set, press_set};

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      event_q <= 8'h00;
      ctrl_q  <= 9'h000;
      limit_q <= DEB_RST;
    end else begin
      event_q <= event_d;
      if (wr_en && paddr == ADDR_CTRL)  ctrl_q  <= pwdata[8:0];
      if (wr_en && paddr == ADDR_LIMIT) limit_q <= pwdata;
    end
  end

  always_comb begin
    prdata = 16'h0000;
    if (rd_en) begin
      case (paddr)
        ADDR_LEVEL: prdata = {12'h000, level_q};
        ADDR_EVENT: prdata = {8'h00, event_q};
        ADDR_CTRL:  prdata = {7'h00, ctrl_q};
        ADDR_LIMIT: prdata = limit_q;
        default:    prdata = 16'h0000;
      endcase
    end
  end

  assign irq = ctrl_q[8] & |(event_q & ctrl_q[7:0]);

endmodule

// File: tb/tb_btn_debounce_apb.sv
// Directed bench for btn_debounce_apb: APB register access, debounce timing,
// sticky events, interrupt gating and reset behaviour.
module tb_btn_debounce_apb;

  logic        pclk = 1'b0;
  logic        preset;
  logic [9:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic [3:0]  buttons;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  btn_debounce_apb #(.NBTN(4), .DEB_RST(16'd1000)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .buttons(buttons), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // Every task starts and ends just after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      @(negedge pclk);
    end
  endtask

  task automatic apb_write(input logic [9:0] a, input logic [15:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); @(negedge pclk);
    penable = 1'b1;
    @(posedge pclk); @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] a, output logic [15:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    @(posedge pclk); @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (prdata !== 16'h0000) begin failures++; $display("FAIL reset_prdata got=%h exp=0000", prdata); end
    checks++; if (pready !== 1'b1) begin failures++; $display("FAIL reset_pready got=%b exp=1", pready); end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_level got=%h exp=0000", d); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_event got=%h exp=0000", d); end
    apb_read(10'h004, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_ctrl got=%h exp=0000", d); end
    apb_read(10'h006, d);
    checks++; if (d !== 16'h03E8) begin failures++; $display("FAIL reset_limit got=%h exp=03e8", d); end
  endtask

  task automatic test_press();
    logic [15:0] d;
    apb_write(10'h006, 16'd4);
    apb_write(10'h004, 16'h010F);
    apb_read(10'h004, d);
    checks++; if (d !== 16'h010F) begin failures++; $display("FAIL ctrl_rb got=%h exp=010f", d); end
    buttons[0] = 1'b1;
    step(5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL press_early_irq got=%b exp=0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL press_irq got=%b exp=1", irq); end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL press_level got=%h exp=0001", d); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL press_event got=%h exp=0001", d); end
  endtask

  task automatic test_clear();
    logic [15:0] d;
    apb_write(10'h002, 16'h0001);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq got=%b exp=0", irq); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL clear_event got=%h exp=0000", d); end
  endtask

  task automatic test_glitch();
    logic [15:0] d;
    buttons[1] = 1'b1;
    step(3);
    buttons[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq cycle=%0d got=%b exp=0", k, irq); end
    end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL glitch_level got=%h exp=0001", d); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL glitch_event got=%h exp=0000", d); end
  endtask

  task automatic test_set_clear_collision();
    logic [15:0] d;
    buttons[0] = 1'b0;
    step(8);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL release_irq_masked got=%b exp=0", irq); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0010) begin failures++; $display("FAIL release_event got=%h exp=0010", d); end
    apb_write(10'h002, 16'h0010);
    // press lands on edge 6, which is the commit edge of the clearing write
    buttons[0] = 1'b1;
    step(4);
    apb_write(10'h002, 16'h0001);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL collide_irq got=%b exp=1", irq); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL collide_event got=%h exp=0001", d); end
    apb_write(10'h002, 16'h00FF);
  endtask

  task automatic test_limit_zero();
    logic [15:0] d;
    apb_write(10'h006, 16'd0);
    buttons[2] = 1'b1;
    step(2);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL l0_early_irq got=%b exp=0", irq); end
    step(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL l0_irq got=%b exp=1", irq); end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL l0_level got=%h exp=0005", d); end
    apb_write(10'h002, 16'h0004);
    buttons[2] = 1'b0;
    step(5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL l0_rel_masked got=%b exp=0", irq); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0040) begin failures++; $display("FAIL l0_rel_event got=%h exp=0040", d); end
    apb_write(10'h004, 16'h014F);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL l0_rel_irq got=%b exp=1", irq); end
    apb_write(10'h002, 16'h0040);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL l0_rel_clr got=%b exp=0", irq); end
  endtask

  task automatic test_disable();
    logic [15:0] d;
    apb_write(10'h004, 16'h000F);
    buttons[3] = 1'b1;
    step(10);
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL dis_level got=%h exp=0001", d); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL dis_event got=%h exp=0000", d); end
    apb_write(10'h004, 16'h010F);
    step(2);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL en_irq got=%b exp=1", irq); end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0009) begin failures++; $display("FAIL en_level got=%h exp=0009", d); end
  endtask

  task automatic test_unmapped();
    logic [15:0] d;
    apb_read(10'h3FE, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h exp=0000", d); end
    apb_write(10'h000, 16'h000F);
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0009) begin failures++; $display("FAIL level_ro got=%h exp=0009", d); end
    apb_write(10'h206, 16'h1234);
    apb_write(10'h3FE, 16'hFFFF);
    apb_read(10'h006, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL alias_limit got=%h exp=0000", d); end
    // prdata must stay 0 during both phases of a write
    paddr = 10'h006; pwdata = 16'h0007; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    #1;
    checks++; if (prdata !== 16'h0000) begin failures++; $display("FAIL wr_setup_prdata got=%h exp=0000", prdata); end
    @(posedge pclk); @(negedge pclk);
    penable = 1'b1;
    #1;
    checks++; if (prdata !== 16'h0000) begin failures++; $display("FAIL wr_access_prdata got=%h exp=0000", prdata); end
    checks++; if (pready !== 1'b1) begin failures++; $display("FAIL pready got=%b exp=1", pready); end
    @(posedge pclk); @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(10'h006, d);
    checks++; if (d !== 16'h0007) begin failures++; $display("FAIL limit_rb got=%h exp=0007", d); end
  endtask

  task automatic test_reset_midcount();
    logic [15:0] d;
    apb_write(10'h002, 16'h00FF);
    buttons = 4'b0000;
    step(12);
    apb_write(10'h006, 16'd100);
    buttons[1] = 1'b1;
    step(20);
    #2 preset = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
    @(negedge pclk);
    preset = 1'b0;
    buttons[1] = 1'b0;
    apb_read(10'h006, d);
    checks++; if (d !== 16'h03E8) begin failures++; $display("FAIL rst_limit got=%h exp=03e8", d); end
    apb_read(10'h000, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_level got=%h exp=0000", d); end
    apb_write(10'h006, 16'd4);
    apb_write(10'h004, 16'h01FF);
    step(10);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_noevent_irq got=%b exp=0", irq); end
    apb_read(10'h002, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rst_noevent got=%h exp=0000", d); end
  endtask

  initial begin
    preset = 1'b1; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; buttons = 4'b0000;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    test_reset();
    test_press();
    test_clear();
    test_glitch();
    test_set_clear_collision();
    test_limit_zero();
    test_disable();
    test_unmapped();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
